// File: rtl/gt_cache_pkg.sv
// Shared widths, FSM state type and line byte-extraction helper for the
// direct-mapped / victim cache miss controller.
package gt_cache_pkg;

    localparam int ADDR_W    = 32;
    localparam int LINE_BITS = 256;
    localparam int OFFSET_W  = 5;
    localparam int IDX_W     = 5;
    localparam int LADDR_W   = ADDR_W - OFFSET_W;
    localparam int TAG_W     = LADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        VPROBE,
        MEMREQ,
        MEMWAIT,
        FILL,
        RESP
    } miss_state_t;

    function automatic logic [7:0] line_byte(input logic [LINE_BITS-1:0] line,
                                             input logic [OFFSET_W-1:0]  sel);
        return line[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gt_line_byte_sel.sv
// Byte selector: picks byte 'sel' out of a 256-bit cache line.
module gt_line_byte_sel
    import gt_cache_pkg::*;
(
    input  logic [LINE_BITS-1:0] line,
    input  logic [OFFSET_W-1:0]  sel,
    output logic [7:0]           byte_o
);

    always_comb begin
        byte_o = line_byte(line, sel);
    end

endmodule

// File: rtl/gt_miss_controller.sv
// Load-miss sequencer: direct-map lookup, victim probe, memory line fetch,
// fill with victim eviction, byte return. Define GT_MISSCTL_STATS_EN for hit/miss counters.
module gt_miss_controller
    import gt_cache_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cpu_req_valid,
    input  logic [ADDR_W-1:0]    cpu_req_addr,
    output logic                 cpu_req_ready,
    output logic                 cpu_resp_valid,
    output logic [7:0]           cpu_resp_data,
    output logic [ADDR_W-1:0]    dm_addr,
    input  logic                 dm_hit,
    input  logic [7:0]           dm_rd_data,
    input  logic [LINE_BITS-1:0] dm_old_line,
    input  logic                 dm_old_valid,
    input  logic [TAG_W-1:0]     dm_old_tag,
    output logic                 dm_fill_en,
    output logic [LINE_BITS-1:0] dm_fill_line,
    output logic [LADDR_W-1:0]   vc_probe_laddr,
    input  logic                 vc_hit,
    input  logic [LINE_BITS-1:0] vc_line,
    output logic                 vc_insert_en,
    output logic [LADDR_W-1:0]   vc_insert_laddr,
    output logic [LINE_BITS-1:0] vc_insert_line,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [LADDR_W-1:0]   mem_req_laddr,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_line
`ifdef GT_MISSCTL_STATS_EN
   ,output logic [31:0]          stat_hits,
    output logic [31:0]          stat_vhits,
    output logic [31:0]          stat_misses
`endif
);

    miss_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    areg_q, areg_d;
    logic [LINE_BITS-1:0] fill_q, fill_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic                 fill_en_q, fill_en_d;
    logic                 ins_en_q, ins_en_d;
    logic [LADDR_W-1:0]   ins_laddr_q, ins_laddr_d;
    logic [LINE_BITS-1:0] ins_line_q, ins_line_d;
    logic                 mem_valid_q, mem_valid_d;
    logic [7:0]           sel_byte;

    gt_line_byte_sel u_byte_sel (
        .line   (fill_q),
        .sel    (areg_q[OFFSET_W-1:0]),
        .byte_o (sel_byte)
    );

    always_comb begin
        state_d      = state_q;
        areg_d       = areg_q;
        fill_d       = fill_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        fill_en_d    = 1'b0;
        ins_en_d     = 1'b0;
        ins_laddr_d  = ins_laddr_q;
        ins_line_d   = ins_line_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    areg_d  = cpu_req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (dm_hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = dm_rd_data;
                    state_d      = IDLE;
                end else begin
                    state_d = VPROBE;
                end
            end
            VPROBE: begin
                if (vc_hit) begin
                    fill_d  = vc_line;
                    state_d = FILL;
                end else begin
                    state_d = MEMREQ;
                end
            end
            MEMREQ: begin
                if (mem_req_ready) state_d = MEMWAIT;
            end
            MEMWAIT: begin
                if (mem_resp_valid) begin
                    fill_d  = mem_resp_line;
                    state_d = FILL;
                end
            end
            FILL: begin
                resp_valid_d = 1'b1;
                resp_data_d  = sel_byte;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered, so they are raised on the transition into
        // the state that owns them; the displaced line is stable beforehand.
        mem_valid_d = (state_d == MEMREQ);
        if (state_d == FILL) begin
            fill_en_d = 1'b1;
            if (dm_old_valid) begin
                ins_en_d    = 1'b1;
                ins_laddr_d = {dm_old_tag, areg_q[OFFSET_W +: IDX_W]};
                ins_line_d  = dm_old_line;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            areg_q       <= '0;
            fill_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            fill_en_q    <= 1'b0;
            ins_en_q     <= 1'b0;
            ins_laddr_q  <= '0;
            ins_line_q   <= '0;
            mem_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            areg_q       <= areg_d;
            fill_q       <= fill_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            fill_en_q    <= fill_en_d;
            ins_en_q     <= ins_en_d;
            ins_laddr_q  <= ins_laddr_d;
            ins_line_q   <= ins_line_d;
            mem_valid_q  <= mem_valid_d;
        end
    end

    assign cpu_req_ready   = (state_q == IDLE);
    assign cpu_resp_valid  = resp_valid_q;
    assign cpu_resp_data   = resp_data_q;
    assign dm_addr         = areg_q;
    assign dm_fill_en      = fill_en_q;
    assign dm_fill_line    = fill_q;
    assign vc_probe_laddr  = areg_q[ADDR_W-1:OFFSET_W];
    assign vc_insert_en    = ins_en_q;
    assign vc_insert_laddr = ins_laddr_q;
    assign vc_insert_line  = ins_line_q;
    assign mem_req_valid   = mem_valid_q;
    assign mem_req_laddr   = areg_q[ADDR_W-1:OFFSET_W];

`ifdef GT_MISSCTL_STATS_EN
    logic [31:0] hits_q, hits_d, vhits_q, vhits_d, misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        vhits_d  = vhits_q;
        misses_d = misses_q;
        if (state_q == LOOKUP && dm_hit && hits_q != '1)
            hits_d = hits_q + 32'd1;
        if (state_q == VPROBE && vc_hit && vhits_q != '1)
            vhits_d = vhits_q + 32'd1;
        if (state_q == VPROBE && !vc_hit && misses_q != '1)
            misses_d = misses_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hits_q   <= '0;
            vhits_q  <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            vhits_q  <= vhits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_vhits  = vhits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_gt_miss_controller.sv
// Scoreboard bench for gt_miss_controller: expected bytes are queued at
// request time and popped by a monitor on every cpu_resp_valid.
module tb_gt_miss_controller;
    import gt_cache_pkg::*;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 cpu_req_valid;
    logic [ADDR_W-1:0]    cpu_req_addr;
    logic                 cpu_req_ready;
    logic                 cpu_resp_valid;
    logic [7:0]           cpu_resp_data;
    logic [ADDR_W-1:0]    dm_addr;
    logic                 dm_hit;
    logic [7:0]           dm_rd_data;
    logic [LINE_BITS-1:0] dm_old_line;
    logic                 dm_old_valid;
    logic [TAG_W-1:0]     dm_old_tag;
    logic                 dm_fill_en;
    logic [LINE_BITS-1:0] dm_fill_line;
    logic [LADDR_W-1:0]   vc_probe_laddr;
    logic                 vc_hit;
    logic [LINE_BITS-1:0] vc_line;
    logic                 vc_insert_en;
    logic [LADDR_W-1:0]   vc_insert_laddr;
    logic [LINE_BITS-1:0] vc_insert_line;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [LADDR_W-1:0]   mem_req_laddr;
    logic                 mem_resp_valid;
    logic [LINE_BITS-1:0] mem_resp_line;
`ifdef GT_MISSCTL_STATS_EN
    logic [31:0]          stat_hits, stat_vhits, stat_misses;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [LINE_BITS-1:0] mline, vline, oline;

    always #5 CLK = ~CLK;

    gt_miss_controller dut (
        .CLK(CLK), .RST(RST),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_data(cpu_resp_data), .dm_addr(dm_addr),
        .dm_hit(dm_hit), .dm_rd_data(dm_rd_data),
        .dm_old_line(dm_old_line), .dm_old_valid(dm_old_valid),
        .dm_old_tag(dm_old_tag), .dm_fill_en(dm_fill_en),
        .dm_fill_line(dm_fill_line), .vc_probe_laddr(vc_probe_laddr),
        .vc_hit(vc_hit), .vc_line(vc_line),
        .vc_insert_en(vc_insert_en), .vc_insert_laddr(vc_insert_laddr),
        .vc_insert_line(vc_insert_line), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_laddr(mem_req_laddr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_line(mem_resp_line)
`ifdef GT_MISSCTL_STATS_EN
       ,.stat_hits(stat_hits), .stat_vhits(stat_vhits), .stat_misses(stat_misses)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (cpu_resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {248'd0, cpu_resp_data}, 256'hDEAD);
            end else begin
                chk("resp_data", {248'd0, cpu_resp_data}, {248'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        dm_hit = 1'b0; dm_rd_data = '0; dm_old_line = '0; dm_old_valid = 1'b0; dm_old_tag = '0;
        vc_hit = 1'b0; vc_line = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_line = '0;
        nclk(2);
        chk("rst_ready",      {255'd0, cpu_req_ready},  256'd1);
        chk("rst_resp_valid", {255'd0, cpu_resp_valid}, 256'd0);
        chk("rst_resp_data",  {248'd0, cpu_resp_data},  256'd0);
        chk("rst_fill_en",    {255'd0, dm_fill_en},     256'd0);
        chk("rst_ins_en",     {255'd0, vc_insert_en},   256'd0);
        chk("rst_mem_valid",  {255'd0, mem_req_valid},  256'd0);
        chk("rst_dm_addr",    {224'd0, dm_addr},        256'd0);
        chk("rst_fill_line",  dm_fill_line,             256'd0);
        RST = 1'b0;
        nclk(1);

        // Direct-map hit: response two edges after acceptance.
        dm_hit = 1'b1; dm_rd_data = 8'hA5;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_0040;
        exp_q.push_back(8'hA5);
        nclk(1);
        cpu_req_valid = 1'b0;
        chk("hit_lookup_ready", {255'd0, cpu_req_ready}, 256'd0);
        chk("hit_dm_addr", {224'd0, dm_addr}, 256'h40);
        chk("hit_no_resp_yet", {255'd0, cpu_resp_valid}, 256'd0);
        nclk(1);
        chk("hit_resp_latency", {255'd0, cpu_resp_valid}, 256'd1);
        chk("hit_ready_back", {255'd0, cpu_req_ready}, 256'd1);
        dm_hit = 1'b0;
        nclk(1);

        // Full miss with memory back-pressure; request held high throughout.
        mline = '0; mline[31:24] = 8'h3C; mline[7:0] = 8'h11;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_0043;
        nclk(1);
        chk("miss_ready_low", {255'd0, cpu_req_ready}, 256'd0);
        nclk(1);
        chk("miss_vc_laddr", {229'd0, vc_probe_laddr}, 256'd2);
        for (int i = 0; i < 3; i++) begin
            nclk(1);
            chk("memreq_valid_held", {255'd0, mem_req_valid}, 256'd1);
            chk("memreq_laddr_stable", {229'd0, mem_req_laddr}, 256'd2);
        end
        mem_req_ready = 1'b1;
        nclk(1);
        mem_req_ready = 1'b0;
        chk("memreq_dropped", {255'd0, mem_req_valid}, 256'd0);
        nclk(2);
        mem_resp_valid = 1'b1; mem_resp_line = mline;
        exp_q.push_back(8'h3C);
        nclk(1);
        mem_resp_valid = 1'b0;
        chk("miss_fill_en", {255'd0, dm_fill_en}, 256'd1);
        chk("miss_fill_line", dm_fill_line, mline);
        chk("miss_no_insert", {255'd0, vc_insert_en}, 256'd0);
        nclk(1);
        chk("miss_fill_pulse", {255'd0, dm_fill_en}, 256'd0);
        chk("miss_resp_valid", {255'd0, cpu_resp_valid}, 256'd1);
        cpu_req_valid = 1'b0;
        nclk(1);
        chk("miss_ready_back", {255'd0, cpu_req_ready}, 256'd1);

        // Spurious memory response while idle.
        mem_resp_valid = 1'b1; mem_resp_line = '1;
        nclk(1);
        mem_resp_valid = 1'b0;
        chk("spurious_no_fill", {255'd0, dm_fill_en}, 256'd0);
        nclk(1);
        chk("spurious_no_fill2", {255'd0, dm_fill_en}, 256'd0);
        chk("spurious_idle", {255'd0, cpu_req_ready}, 256'd1);

        // Victim hit with a valid displaced line.
        vline = '0; vline[255:248] = 8'h7E; vline[7:0] = 8'h01;
        oline = {8{32'hCAFE_0001}};
        vc_hit = 1'b1; vc_line = vline;
        dm_old_valid = 1'b1; dm_old_line = oline; dm_old_tag = 22'h1234;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_003F;
        exp_q.push_back(8'h7E);
        nclk(1);
        cpu_req_valid = 1'b0;
        chk("vhit_no_memreq0", {255'd0, mem_req_valid}, 256'd0);
        nclk(1);
        chk("vhit_no_memreq1", {255'd0, mem_req_valid}, 256'd0);
        nclk(1);
        chk("vhit_fill_en", {255'd0, dm_fill_en}, 256'd1);
        chk("vhit_fill_line", dm_fill_line, vline);
        chk("vhit_ins_en", {255'd0, vc_insert_en}, 256'd1);
        chk("vhit_ins_line", vc_insert_line, oline);
        chk("vhit_ins_laddr", {229'd0, vc_insert_laddr}, 256'h24681);
        chk("vhit_no_memreq2", {255'd0, mem_req_valid}, 256'd0);
        nclk(1);
        chk("vhit_ins_pulse", {255'd0, vc_insert_en}, 256'd0);
        vc_hit = 1'b0; dm_old_valid = 1'b0;
        nclk(1);

        // Reset during MEMWAIT; the late memory response must be dropped.
        mem_req_ready = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_0080;
        nclk(1);
        cpu_req_valid = 1'b0;
        nclk(2);
        chk("rstmw_memreq", {255'd0, mem_req_valid}, 256'd1);
        nclk(1);
        mem_req_ready = 1'b0;
        chk("rstmw_in_wait", {255'd0, mem_req_valid}, 256'd0);
        chk("rstmw_busy", {255'd0, cpu_req_ready}, 256'd0);
        RST = 1'b1;
        #1;
        chk("rstmw_async_ready", {255'd0, cpu_req_ready}, 256'd1);
        nclk(1);
        RST = 1'b0;
        nclk(1);
        mem_resp_valid = 1'b1; mem_resp_line = mline;
        nclk(1);
        mem_resp_valid = 1'b0;
        chk("rstmw_no_fill", {255'd0, dm_fill_en}, 256'd0);
        nclk(2);
        chk("rstmw_no_fill2", {255'd0, dm_fill_en}, 256'd0);
        chk("rstmw_idle", {255'd0, cpu_req_ready}, 256'd1);

        nclk(3);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gt_miss_controller.md
Name: gt_miss_controller

Overview:
Sequencer sitting between the CPU load port and the direct-mapped cache / victim cache pair. Accepts one byte-load request at a time and presents it to the direct-mapped array. On a miss it probes the victim cache, then falls back to a main-memory line fetch. It fills the direct-mapped line and pushes the displaced line into the victim cache, then returns the byte.

Parameters:
ADDR_W, 32, byte address width
LINE_BITS, 256, cache line width (32 bytes)
OFFSET_W, 5, byte-offset bits within a line
IDX_W, 5, direct-map index bits (32 lines)
LADDR_W, ADDR_W-OFFSET_W, line address width (27)

Ports:
CLK  in  1  clock, all state on posedge
RST  in  1  asynchronous active-high reset
cpu_req_valid  in  1  load request valid
cpu_req_addr  in  ADDR_W  byte address
cpu_req_ready  out  1  controller can accept a request
cpu_resp_valid  out  1  one-cycle pulse, byte returned
cpu_resp_data  out  8  returned byte
dm_addr  out  ADDR_W  lookup/fill address to direct-map array
dm_hit  in  1  combinational hit for dm_addr
dm_rd_data  in  8  byte at dm_addr (valid when dm_hit)
dm_old_line  in  LINE_BITS  current line at index of dm_addr
dm_old_valid  in  1  that line holds valid data
dm_old_tag  in  ADDR_W-OFFSET_W-IDX_W  tag of that line
dm_fill_en  out  1  write fill line at index of dm_addr
dm_fill_line  out  LINE_BITS  fill data
vc_probe_laddr  out  LADDR_W  victim-cache probe line address
vc_hit  in  1  combinational victim hit
vc_line  in  LINE_BITS  victim line on hit
vc_insert_en  out  1  insert displaced line
vc_insert_laddr  out  LADDR_W  {dm_old_tag, index}
vc_insert_line  out  LINE_BITS  displaced line
mem_req_valid  out  1  line fetch request
mem_req_ready  in  1  memory accepts request
mem_req_laddr  out  LADDR_W  line address
mem_resp_valid  in  1  fetched line valid (single cycle)
mem_resp_line  in  LINE_BITS  fetched line

Behaviour:
- Reset: state IDLE; cpu_req_ready=1; cpu_resp_valid=0, cpu_resp_data=0; dm_fill_en=0; vc_insert_en=0; mem_req_valid=0; captured address=0; all line registers=0. Reset mid-transaction aborts it, emits no response, and drops any later mem_resp_valid until a new request is issued.
- IDLE: cpu_req_ready=1. On cpu_req_valid, latch the address into areg and go to LOOKUP. dm_addr=areg from LOOKUP onward.
- LOOKUP (1 cycle): dm_hit=1 -> cpu_resp_valid=1, cpu_resp_data=dm_rd_data, go to IDLE. Hit latency = 2 cycles from acceptance to response. Miss -> VPROBE.
- VPROBE (1 cycle): vc_probe_laddr=areg[ADDR_W-1:OFFSET_W].
  - vc_hit -> latch vc_line as the fill line, go to FILL.
  - Miss -> MEMREQ.
- MEMREQ: mem_req_valid=1 and mem_req_laddr held stable until the cycle mem_req_ready=1, then go to MEMWAIT. Never deassert valid before acceptance.
- MEMWAIT: wait unbounded for mem_resp_valid. Latch mem_resp_line, go to FILL. mem_resp_valid in any other state is ignored.
- FILL (1 cycle): dm_fill_en=1, dm_fill_line=fill line.
  - If dm_old_valid: vc_insert_en=1 in the same cycle with dm_old_line and {dm_old_tag, areg index}.
  - A victim hit that swaps a line is allowed. Victim removal of the hit entry is the victim cache's responsibility.
  - Go to RESP.
- RESP (1 cycle): cpu_resp_data = byte (areg offset × 8) of the fill line, cpu_resp_valid=1, go to IDLE.
- cpu_req_ready=0 in every state except IDLE; requests are never queued.
- Enable strobes are single-cycle pulses, registered outputs.

Optional Feature:
GT_MISSCTL_STATS_EN: adds outputs stat_hits, stat_vhits, stat_misses (32 bits each). They increment on a LOOKUP hit, a VPROBE hit, and a MEMREQ entry respectively. They reset to 0 on RST and saturate at all-ones. Without the macro the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package gt_cache_pkg holds:
  - Widths: ADDR_W, LINE_BITS, OFFSET_W, IDX_W, LADDR_W.
  - State enum: IDLE, LOOKUP, VPROBE, MEMREQ, MEMWAIT, FILL, RESP.
  - Helper function extracting byte N of a line.
- One sub-module: gt_line_byte_sel, the 256-to-8 byte mux used in RESP.

Test Plan:
- Reset then request 0x0000_0040 with dm_hit=1, dm_rd_data=0xA5 -> cpu_resp_valid two cycles after acceptance, data 0xA5, ready back next cycle.
- Miss on both caches with mem_req_ready held low 3 cycles -> mem_req_valid high and laddr 0x0000002 stable throughout. Memory responds with line byte 3 = 0x3C and request addr 0x43 -> dm_fill_en pulse, then response 0x3C.
- Victim hit (vc_line byte 31 = 0x7E, addr 0x..1F) -> no mem_req_valid. FILL asserts dm_fill_en and vc_insert_en (dm_old_valid=1) with the old line/laddr. Response 0x7E.
- Fill with dm_old_valid=0 -> vc_insert_en stays 0.
- RST asserted during MEMWAIT, then mem_resp_valid pulsed -> no fill, no response, state IDLE, cpu_req_ready=1 asynchronously.
- Spurious mem_resp_valid in IDLE, and cpu_req_valid held high during a miss -> ignored; exactly one response per accepted request.
